// File: rtl/decoder_onehot_acc.sv
// Registered one-hot decoder with optional burst accumulation into a single OR-mask.
// Optional macro DECODER_ONEHOT_DUP_EN adds out_dup (duplicate index seen inside a burst).
module decoder_onehot_acc #(
    parameter int unsigned IDX_WIDTH = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IDX_WIDTH-1:0]    in_idx,
    input  logic                    in_val,
    input  logic                    in_last,
    output logic                    in_rdy,
    input  logic                    acc_mode,
    input  logic                    clr,
    output logic [2**IDX_WIDTH-1:0] out_mask,
    output logic [IDX_WIDTH:0]      out_cnt,
    output logic                    out_val,
    input  logic                    out_rdy
`ifdef DECODER_ONEHOT_DUP_EN
    ,
    output logic                    out_dup
`endif
);

    localparam int unsigned OUT_WIDTH = 2**IDX_WIDTH;
    localparam int unsigned CNT_WIDTH = IDX_WIDTH + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    logic [0:0]           state;
    logic [0:0]           state_nxt;
    logic [OUT_WIDTH-1:0] acc;
    logic [OUT_WIDTH-1:0] acc_nxt;
    logic [OUT_WIDTH-1:0] dec;
    logic [OUT_WIDTH-1:0] emit_mask;
    logic [IDX_WIDTH-1:0] bit_pos;
    logic [CNT_WIDTH-1:0] emit_cnt;
    logic                 accept;
    logic                 emit;

    assign in_rdy  = (!out_val || out_rdy) && !clr;
    assign accept  = in_val && in_rdy;
    // Legacy ordering maps index k to bit OUT_WIDTH-1-k, which is simply ~k.
    assign bit_pos = MSB_FIRST ? ~in_idx : in_idx;
    assign dec     = OUT_WIDTH'(1) << bit_pos;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        emit      = 1'b0;
        emit_mask = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!acc_mode || in_last) begin
                        emit      = 1'b1;
                        emit_mask = dec;
                    end else begin
                        acc_nxt   = dec;
                        state_nxt = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (clr) begin
                    acc_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else if (accept) begin
                    if (in_last) begin
                        emit      = 1'b1;
                        emit_mask = acc | dec;
                        acc_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        acc_nxt = acc | dec;
                    end
                end
            end
            default: begin
                acc_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        emit_cnt = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            emit_cnt = emit_cnt + CNT_WIDTH'(emit_mask[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            acc      <= '0;
            out_val  <= 1'b0;
            out_mask <= '0;
            out_cnt  <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            if (emit) begin
                out_val  <= 1'b1;
                out_mask <= emit_mask;
                out_cnt  <= emit_cnt;
            end else if (out_rdy) begin
                out_val  <= 1'b0;
            end
        end
    end

`ifdef DECODER_ONEHOT_DUP_EN
    logic dup_acc;
    logic dup_acc_nxt;
    logic emit_dup;
    logic hit;

    // A beat hits when its bit is already present in the open burst.
    assign hit = |(acc & dec);

    always_comb begin
        dup_acc_nxt = dup_acc;
        emit_dup    = 1'b0;
        if (state == ST_ACCUM) begin
            if (clr) begin
                dup_acc_nxt = 1'b0;
            end else if (accept) begin
                if (in_last) begin
                    emit_dup    = dup_acc | hit;
                    dup_acc_nxt = 1'b0;
                end else begin
                    dup_acc_nxt = dup_acc | hit;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dup_acc <= 1'b0;
            out_dup <= 1'b0;
        end else begin
            dup_acc <= dup_acc_nxt;
            if (emit) begin
                out_dup <= emit_dup;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decoder_onehot_acc.sv
// Directed bench for decoder_onehot_acc: one instance per bit ordering, shared stimulus.
module tb_decoder_onehot_acc;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_idx;
    logic        in_val;
    logic        in_last;
    logic        acc_mode;
    logic        clr;
    logic        out_rdy;
    logic        in_rdy;
    logic [15:0] out_mask;
    logic [4:0]  out_cnt;
    logic        out_val;
    logic        in_rdy1;
    logic [15:0] out_mask1;
    logic [4:0]  out_cnt1;
    logic        out_val1;
`ifdef DECODER_ONEHOT_DUP_EN
    logic        out_dup;
    logic        out_dup1;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    decoder_onehot_acc #(.IDX_WIDTH(4), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .reset(reset), .in_idx(in_idx), .in_val(in_val), .in_last(in_last),
        .in_rdy(in_rdy), .acc_mode(acc_mode), .clr(clr), .out_mask(out_mask),
        .out_cnt(out_cnt), .out_val(out_val), .out_rdy(out_rdy)
`ifdef DECODER_ONEHOT_DUP_EN
        , .out_dup(out_dup)
`endif
    );

    decoder_onehot_acc #(.IDX_WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .in_idx(in_idx), .in_val(in_val), .in_last(in_last),
        .in_rdy(in_rdy1), .acc_mode(acc_mode), .clr(clr), .out_mask(out_mask1),
        .out_cnt(out_cnt1), .out_val(out_val1), .out_rdy(out_rdy)
`ifdef DECODER_ONEHOT_DUP_EN
        , .out_dup(out_dup1)
`endif
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [3:0] idx, input logic last);
        in_val  = 1'b1;
        in_idx  = idx;
        in_last = last;
        cyc();
        in_val  = 1'b0;
        in_last = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_idx = '0; in_val = 1'b0; in_last = 1'b0;
        acc_mode = 1'b0; clr = 1'b0; out_rdy = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        #1;
        chk("rst_val",  32'(out_val), 32'h0);
        chk("rst_mask", 32'(out_mask), 32'h0);
        chk("rst_cnt",  32'(out_cnt), 32'h0);
        chk("rst_rdy",  32'(in_rdy), 32'h1);
        chk("rst_rdy1", 32'(in_rdy1), 32'h1);

        // single-beat decode
        acc_mode = 1'b0;
        beat(4'd3, 1'b0);
        chk("t1_val",   32'(out_val), 32'h1);
        chk("t1_mask",  32'(out_mask), 32'h1000);
        chk("t1_cnt",   32'(out_cnt), 32'h1);
        chk("t1_mask1", 32'(out_mask1), 32'h0008);
        cyc();
        chk("t1_drain", 32'(out_val), 32'h0);

        // three-beat burst
        acc_mode = 1'b1;
        beat(4'd0, 1'b0);
        chk("t2_noemit", 32'(out_val), 32'h0);
        beat(4'd5, 1'b0);
        beat(4'd15, 1'b1);
        chk("t2_val",   32'(out_val), 32'h1);
        chk("t2_mask",  32'(out_mask), 32'h8401);
        chk("t2_cnt",   32'(out_cnt), 32'h3);
        chk("t2_mask1", 32'(out_mask1), 32'h8021);
`ifdef DECODER_ONEHOT_DUP_EN
        chk("t2_dup",   32'(out_dup), 32'h0);
`endif
        cyc();

        // duplicate index inside a burst
        beat(4'd2, 1'b0);
        beat(4'd2, 1'b1);
        chk("t3_mask",  32'(out_mask), 32'h2000);
        chk("t3_cnt",   32'(out_cnt), 32'h1);
        chk("t3_mask1", 32'(out_mask1), 32'h0004);
`ifdef DECODER_ONEHOT_DUP_EN
        chk("t3_dup",   32'(out_dup), 32'h1);
        chk("t3_dup1",  32'(out_dup1), 32'h1);
`endif
        cyc();

        // backpressure: output held, input blocked, then replaced on release
        acc_mode = 1'b0;
        out_rdy  = 1'b0;
        beat(4'd10, 1'b0);
        in_val = 1'b1; in_idx = 4'd11;
        #1;
        chk("t4_rdy0", 32'(in_rdy), 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t4_hold_val",  32'(out_val), 32'h1);
            chk("t4_hold_mask", 32'(out_mask), 32'h0020);
        end
        out_rdy = 1'b1; in_idx = 4'd7;
        #1;
        chk("t4_rdy1", 32'(in_rdy), 32'h1);
        cyc();
        in_val = 1'b0;
        chk("t4_val",  32'(out_val), 32'h1);
        chk("t4_mask", 32'(out_mask), 32'h0100);
        chk("t4_cnt",  32'(out_cnt), 32'h1);
        cyc();
        chk("t4_drain", 32'(out_val), 32'h0);

        // reset mid-burst discards the open accumulator
        acc_mode = 1'b1;
        beat(4'd1, 1'b0);
        beat(4'd2, 1'b0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t5_rstval", 32'(out_val), 32'h0);
        beat(4'd4, 1'b1);
        chk("t5_val",   32'(out_val), 32'h1);
        chk("t5_mask",  32'(out_mask), 32'h0800);
        chk("t5_cnt",   32'(out_cnt), 32'h1);
        chk("t5_mask1", 32'(out_mask1), 32'h0010);
        cyc();

        // clr drops the open burst without output
        beat(4'd1, 1'b0);
        beat(4'd2, 1'b0);
        clr = 1'b1;
        #1;
        chk("t6_clr_rdy", 32'(in_rdy), 32'h0);
        cyc();
        clr = 1'b0;
        chk("t6_clr_val", 32'(out_val), 32'h0);
        beat(4'd9, 1'b1);
        chk("t6_mask",  32'(out_mask), 32'h0040);
        chk("t6_cnt",   32'(out_cnt), 32'h1);
        chk("t6_mask1", 32'(out_mask1), 32'h0200);
        chk("t6_val1",  32'(out_val1), 32'h1);
        chk("t6_cnt1",  32'(out_cnt1), 32'h1);
        cyc();

        // full burst: count reaches OUT_WIDTH without wrapping
        for (int i = 0; i < 16; i++) begin
            beat(4'(i), (i == 15) ? 1'b1 : 1'b0);
        end
        chk("t7_mask", 32'(out_mask), 32'hFFFF);
        chk("t7_cnt",  32'(out_cnt), 32'd16);
`ifdef DECODER_ONEHOT_DUP_EN
        chk("t7_dup",  32'(out_dup), 32'h0);
`endif
        cyc();
        chk("t7_drain", 32'(out_val), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
